// File: rtl/axis_retransmit_fifo_mem.sv
// ---------------------------------------------------------------------------
// axis_retransmit_fifo_mem
//   Simple dual-port RAM with one write port and one registered read port.
//   Written so synthesis can map it onto block RAM.
//   The read register doubles as the output word register of the FIFO.
//   It therefore has a synchronous reset so the FIFO output data reads as
//   zero after reset. The storage array itself is never reset.
//
// Ports:
//   clk     - clock
//   sreset  - synchronous active-high reset (read register only)
//   wr_en   - write strobe
//   wr_addr - write address
//   wr_data - word to store
//   rd_en   - load the read register from rd_addr
//   rd_addr - read address
//   rd_data - registered read word
// ---------------------------------------------------------------------------
module axis_retransmit_fifo_mem #(
  parameter int WIDTH      = 10,
  parameter int LOG2_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  sreset,
  input  logic                  wr_en,
  input  logic [LOG2_DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [LOG2_DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**LOG2_DEPTH];

  // Write port: the storage array has no reset, so it stays BRAM friendly.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: a registered read that only updates when a new word is fetched.
  // The FIFO relies on this to hold its output word stable under backpressure.
  always_ff @(posedge clk) begin
    if (sreset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axis_retransmit_fifo.sv
// ---------------------------------------------------------------------------
// axis_retransmit_fifo
//   A packet FIFO with a speculative read side. Words leave on axis_o but
//   remain in memory until downstream acknowledges them.
//     - ack frees every packet whose tlast has handshaken on axis_o.
//     - nack rewinds the read pointer to the oldest unfreed word, so every
//       unfreed packet is replayed.
//   Only complete (tlast-written) packets are ever presented on the output.
//
// Ports:
//   clk, sreset                  - clock, synchronous active-high reset
//   axis_i_*                     - AXI-Stream input (tready = not full)
//   axis_o_*                     - AXI-Stream output, registered, one word deep
//   ack                          - pulse: free all fully sent packets
//   nack                         - pulse: rewind and replay all unfreed data
//   unacked                      - high while a fully sent packet awaits ack
// ---------------------------------------------------------------------------
module axis_retransmit_fifo #(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int LOG2_DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      sreset,
  output logic                      axis_i_tready,
  input  logic                      axis_i_tvalid,
  input  logic                      axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0]   axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                      axis_o_tready,
  output logic                      axis_o_tvalid,
  output logic                      axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]   axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
  input  logic                      ack,
  input  logic                      nack,
  output logic                      unacked
);

  localparam int PTR_W  = LOG2_DEPTH + 1;
  localparam int DATA_W = 8 * AXIS_BYTES;
  localparam int WORD_W = DATA_W + AXIS_USER_BITS + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // Pointer set. Each pointer carries one extra wrap bit, so the FIFO can
  // tell full apart from empty.
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] committed_wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] sent_ptr;
  logic [PTR_W-1:0] free_ptr;
  logic [PTR_W-1:0] out_ptr;

  logic [PTR_W-1:0]  sent_hs;
  logic [PTR_W-1:0]  free_next;
  logic [PTR_W-1:0]  sent_next;
  logic              full;
  logic              in_hs;
  logic              out_hs;
  logic              fetch;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;

  // Full is measured against free_ptr, not rd_ptr. Sent but unacknowledged
  // words must survive until ack, so they still occupy space.
  assign full = (wr_ptr[LOG2_DEPTH-1:0] == free_ptr[LOG2_DEPTH-1:0]) &&
                (wr_ptr[LOG2_DEPTH] != free_ptr[LOG2_DEPTH]);
  assign axis_i_tready = !full;
  assign in_hs  = axis_i_tvalid && !full;
  assign out_hs = axis_o_tvalid && axis_o_tready;

  // sent_hs already includes a tlast handshake that happens this cycle. That
  // lets an ack in the same cycle free the packet that is finishing.
  // An ack+nack pair rewinds to the post-ack free pointer.
  assign sent_hs   = (out_hs && axis_o_tlast) ? out_ptr : sent_ptr;
  assign free_next = ack ? sent_hs : free_ptr;
  assign sent_next = nack ? free_next : sent_hs;

  // Words are only fetched from complete packets. A nack cycle never fetches,
  // because the read pointer is being rewound underneath it.
  assign fetch = (rd_ptr != committed_wr_ptr) &&
                 (!axis_o_tvalid || axis_o_tready) && !nack;

  assign wr_word       = {axis_i_tlast, axis_i_tdata, axis_i_tuser};
  assign axis_o_tlast  = rd_word[WORD_W-1];
  assign axis_o_tdata  = rd_word[WORD_W-2 -: DATA_W];
  assign axis_o_tuser  = rd_word[AXIS_USER_BITS-1:0];

  axis_retransmit_fifo_mem #(
    .WIDTH      (WORD_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_mem (
    .clk     (clk),
    .sreset  (sreset),
    .wr_en   (in_hs),
    .wr_addr (wr_ptr[LOG2_DEPTH-1:0]),
    .wr_data (wr_word),
    .rd_en   (fetch),
    .rd_addr (rd_ptr[LOG2_DEPTH-1:0]),
    .rd_data (rd_word)
  );

  // Write side. Every accepted word advances wr_ptr. A packet becomes
  // visible to the reader only once its tlast has been stored.
  always_ff @(posedge clk) begin
    if (sreset) begin
      wr_ptr           <= '0;
      committed_wr_ptr <= '0;
    end else if (in_hs) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      if (axis_i_tlast) begin
        committed_wr_ptr <= wr_ptr + PTR_ONE;
      end
    end
  end

  // Read and retransmit side. A fetch loads the output word and records
  // out_ptr, the position just past that word. When a tlast handshake is
  // accepted, sent_ptr moves to out_ptr. A nack drops tvalid and rewinds
  // both rd_ptr and sent_ptr to the oldest unfreed word. Any handshake in
  // the nack cycle is forgotten; that word will be sent again.
  always_ff @(posedge clk) begin
    if (sreset) begin
      rd_ptr        <= '0;
      sent_ptr      <= '0;
      free_ptr      <= '0;
      out_ptr       <= '0;
      axis_o_tvalid <= 1'b0;
      unacked       <= 1'b0;
    end else begin
      free_ptr <= free_next;
      sent_ptr <= sent_next;
      unacked  <= (sent_next != free_next);
      if (nack) begin
        rd_ptr        <= free_next;
        axis_o_tvalid <= 1'b0;
      end else if (fetch) begin
        rd_ptr        <= rd_ptr + PTR_ONE;
        out_ptr       <= rd_ptr + PTR_ONE;
        axis_o_tvalid <= 1'b1;
      end else if (out_hs) begin
        axis_o_tvalid <= 1'b0;
      end
    end
  end

endmodule
